// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the 2x2 pooling sequencer.
//   state_e  : sequencer states (IDLE, RD, LAST, WR, DONE)
//   MODE_*   : pooling mode encodings carried on mode_i
//   out_size : side length of the pooled map (floor(img/2))
//   acc_w    : accumulator width, two guard bits for a sum of four pixels
package pool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAST,
    WR,
    DONE
  } state_e;

  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int out_size(input int img);
    return img / 2;
  endfunction

  function automatic int acc_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/pool_acc.sv
// Time-multiplexed accumulator / max comparator, one pixel per enabled cycle.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   init_i       : current din_i is the first pixel of a window (loads acc)
//   en_i         : din_i is valid this cycle, update the accumulator
//   mode_i       : MODE_AVG sums, MODE_MAX keeps the signed maximum
//   din_i        : signed pixel
//   result_o     : pooled value including the pixel on din_i this cycle
module pool_acc
  import pool_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     init_i,
  input  logic                     en_i,
  input  logic                     mode_i,
  input  logic signed [DATA_W-1:0] din_i,
  output logic signed [DATA_W-1:0] result_o
);

  localparam int ACC_W = acc_w(DATA_W);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] din_ext;

  assign din_ext = {{(ACC_W-DATA_W){din_i[DATA_W-1]}}, din_i};

  always_comb begin
    acc_d = acc_q;
    if (init_i) begin
      acc_d = din_ext;
    end else if (mode_i == MODE_MAX) begin
      if (din_ext > acc_q) acc_d = din_ext;
    end else begin
      acc_d = acc_q + din_ext;
    end
  end

  // Result looks through to acc_d so the last pixel can be folded in and
  // registered by the caller in the same cycle. Bits [ACC_W-1:2] are the
  // arithmetic >>>2 truncated to DATA_W (floor division by 4).
  assign result_o = (mode_i == MODE_MAX) ? acc_d[DATA_W-1:0] : acc_d[ACC_W-1:2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pool2x2_sequencer.sv
// 2x2 stride-2 pooling sequencer over a row-major IMG_SIZE x IMG_SIZE map.
// Reads one pixel per cycle, writes one pooled value per 6-cycle window.
// Ports:
//   clk_i, rst_i         : clock, async active-high reset
//   start_i, mode_i      : run request (IDLE only), 0 = average / 1 = max
//   busy_o, done_o       : run in progress, one-cycle end-of-run pulse
//   rd_en_o, rd_addr_o   : pixel read strobe/address, data returns 1 cycle later
//   rd_data_i            : pixel read data
//   wr_en_o, wr_addr_o,
//   wr_data_o            : pooled result write port
module pool2x2_sequencer
  import pool_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int IMG_SIZE = 28,
  parameter int ADDR_W   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  localparam int OUT_SIZE = out_size(IMG_SIZE);
  localparam logic [ADDR_W-1:0] IMG_A    = ADDR_W'(IMG_SIZE);
  localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_SIZE);
  localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

  if (IMG_SIZE < 2) begin : g_bad_img
    $error("pool2x2_sequencer: IMG_SIZE must be at least 2");
  end
  if ((64'd1 << ADDR_W) < 64'(IMG_SIZE * IMG_SIZE)) begin : g_bad_addr
    $error("pool2x2_sequencer: ADDR_W too narrow for IMG_SIZE^2");
  end

  state_e              state_q;
  logic [1:0]          k_q;
  logic [ADDR_W-1:0]   orow_q, ocol_q;
  logic [ADDR_W-1:0]   orow_d, ocol_d;
  logic                mode_q;
  logic                last_win;
  logic                acc_init, acc_en;
  logic [DATA_W-1:0]   acc_result;

  // Pixel k of window (orow, ocol): row = 2*orow + k[1], col = 2*ocol + k[0].
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] orow,
                                                 input logic [ADDR_W-1:0] ocol,
                                                 input logic [1:0]        k);
    logic [ADDR_W-1:0] row, col;
    row = {orow[ADDR_W-2:0], k[1]};
    col = {ocol[ADDR_W-2:0], k[0]};
    return row * IMG_A + col;
  endfunction

  assign last_win = (orow_q == OUT_LAST) && (ocol_q == OUT_LAST);

  always_comb begin
    ocol_d = ocol_q + A_ONE;
    orow_d = orow_q;
    if (ocol_q == OUT_LAST) begin
      ocol_d = '0;
      orow_d = orow_q + A_ONE;
    end
  end

  // Data for read k arrives while k+1 is being issued (or in LAST for k3).
  assign acc_init = (state_q == RD) && (k_q == 2'd1);
  assign acc_en   = ((state_q == RD) && (k_q != 2'd0)) || (state_q == LAST);

  pool_acc #(.DATA_W(DATA_W)) u_acc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .init_i   (acc_init),
    .en_i     (acc_en),
    .mode_i   (mode_q),
    .din_i    (rd_data_i),
    .result_o (acc_result)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      k_q       <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      mode_q    <= MODE_AVG;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      done_o  <= 1'b0;
      wr_en_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= RD;
            busy_o    <= 1'b1;
            mode_q    <= mode_i;
            orow_q    <= '0;
            ocol_q    <= '0;
            k_q       <= '0;
            rd_en_o   <= 1'b1;
            rd_addr_o <= '0;
          end
        end
        RD: begin
          if (k_q == 2'd3) begin
            state_q <= LAST;
            rd_en_o <= 1'b0;
          end else begin
            k_q       <= k_q + 2'd1;
            rd_addr_o <= pix_addr(orow_q, ocol_q, k_q + 2'd1);
          end
        end
        LAST: begin
          state_q   <= WR;
          wr_en_o   <= 1'b1;
          wr_addr_o <= orow_q * OUT_A + ocol_q;
          wr_data_o <= acc_result;
        end
        WR: begin
          if (last_win) begin
            state_q <= DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            state_q   <= RD;
            orow_q    <= orow_d;
            ocol_q    <= ocol_d;
            k_q       <= '0;
            rd_en_o   <= 1'b1;
            rd_addr_o <= pix_addr(orow_d, ocol_d, 2'd0);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool2x2_sequencer.sv
// Self-checking bench: two instances (IMG_SIZE 4 and 5) share control inputs,
// each with its own pixel memory; results are compared against a window-level
// reference model of the pooling rules and the documented cycle timing.
module tb_pool2x2_sequencer;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic mode;

  logic        busy0, done0, rd_en0, wr_en0;
  logic [9:0]  rd_addr0, wr_addr0;
  logic [15:0] rd_data0, wr_data0;
  logic        busy1, done1, rd_en1, wr_en1;
  logic [9:0]  rd_addr1, wr_addr1;
  logic [15:0] rd_data1, wr_data1;

  logic signed [15:0] mem0 [1024];
  logic signed [15:0] mem1 [1024];

  ev_t wq0[$], wq1[$], rq0[$], rq1[$];
  int  dq0[$], dq1[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pool2x2_sequencer #(.DATA_W(16), .IMG_SIZE(4), .ADDR_W(10)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
    .busy_o(busy0), .done_o(done0),
    .rd_en_o(rd_en0), .rd_addr_o(rd_addr0), .rd_data_i(rd_data0),
    .wr_en_o(wr_en0), .wr_addr_o(wr_addr0), .wr_data_o(wr_data0)
  );

  pool2x2_sequencer #(.DATA_W(16), .IMG_SIZE(5), .ADDR_W(10)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
    .busy_o(busy1), .done_o(done1),
    .rd_en_o(rd_en1), .rd_addr_o(rd_addr1), .rd_data_i(rd_data1),
    .wr_en_o(wr_en1), .wr_addr_o(wr_addr1), .wr_data_o(wr_data1)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en0) rd_data0 <= mem0[rd_addr0];
    if (rd_en1) rd_data1 <= mem1[rd_addr1];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en0) rq0.push_back('{addr: int'(rd_addr0), data: 0, cyc: cyc});
      if (rd_en1) rq1.push_back('{addr: int'(rd_addr1), data: 0, cyc: cyc});
      if (wr_en0) wq0.push_back('{addr: int'(wr_addr0), data: int'(wr_data0), cyc: cyc});
      if (wr_en1) wq1.push_back('{addr: int'(wr_addr1), data: int'(wr_data1), cyc: cyc});
      if (done0) dq0.push_back(cyc);
      if (done1) dq1.push_back(cyc);
    end
  end

  function automatic int pix(input int inst, input int a);
    logic [9:0] ai;
    ai = a[9:0];
    if (inst == 0) return int'(mem0[ai]);
    return int'(mem1[ai]);
  endfunction

  function automatic int floor_div4(input int s);
    int q;
    q = s / 4;
    if (s < 0 && (s % 4) != 0) q = q - 1;
    return q;
  endfunction

  task automatic clear_queues();
    wq0.delete(); wq1.delete(); rq0.delete(); rq1.delete(); dq0.delete(); dq1.delete();
  endtask

  // One complete run on both instances, compared against the window model.
  task automatic run_and_verify(input string tag, input logic m,
                                input bit extra_starts, input bit wiggle_mode);
    int t, img, outs, nwin, sum, best, res, a, p, illegal;
    ev_t gw[$];
    ev_t gr[$];
    int  gd[$];
    logic exp_busy;
    clear_queues();
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    t     = cyc;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = extra_starts && (c == 3 || c == 10 || c == 25);
      if (wiggle_mode) mode = logic'($urandom_range(0, 1));
      exp_busy = (c <= 24);
      vectors++;
      if (busy0 !== exp_busy || busy1 !== exp_busy) begin
        miscompares++;
        $display("FAIL %s busy at T+%0d: got %b/%b want %b", tag, c, busy0, busy1, exp_busy);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin gw = wq0; gr = rq0; gd = dq0; img = 4; end
      else        begin gw = wq1; gr = rq1; gd = dq1; img = 5; end
      outs = img / 2;
      nwin = outs * outs;
      vectors++;
      if (gd.size() != 1 || gd[0] != t + 6 * nwin + 1) begin
        miscompares++;
        $display("FAIL %s done inst%0d: got %0d pulses first at T+%0d want 1 at T+%0d",
                 tag, i, gd.size(), (gd.size() > 0) ? gd[0] - t : -1, 6 * nwin + 1);
      end
      vectors++;
      if (gw.size() != nwin) begin
        miscompares++;
        $display("FAIL %s write count inst%0d: got %0d want %0d", tag, i, gw.size(), nwin);
      end
      vectors++;
      if (gr.size() != 4 * nwin) begin
        miscompares++;
        $display("FAIL %s read count inst%0d: got %0d want %0d", tag, i, gr.size(), 4 * nwin);
      end
      for (int w = 0; w < nwin; w++) begin
        sum  = 0;
        best = -(1 << 20);
        for (int k = 0; k < 4; k++) begin
          a = (2 * (w / outs) + k / 2) * img + 2 * (w % outs) + k % 2;
          p = pix(i, a);
          sum += p;
          if (p > best) best = p;
          if (4 * w + k < gr.size()) begin
            vectors++;
            if (gr[4*w+k].addr != a || gr[4*w+k].cyc != t + 1 + 6 * w + k) begin
              miscompares++;
              $display("FAIL %s read inst%0d w%0d k%0d: got addr %0d at T+%0d want addr %0d at T+%0d",
                       tag, i, w, k, gr[4*w+k].addr, gr[4*w+k].cyc - t, a, 1 + 6 * w + k);
            end
          end
        end
        res = (m == 1'b1) ? best : floor_div4(sum);
        if (w < gw.size()) begin
          vectors++;
          if (gw[w].addr != w || gw[w].data != (res & 32'hFFFF) || gw[w].cyc != t + 6 + 6 * w) begin
            miscompares++;
            $display("FAIL %s write inst%0d w%0d: got (%0d,%04h)@T+%0d want (%0d,%04h)@T+%0d",
                     tag, i, w, gw[w].addr, gw[w].data, gw[w].cyc - t, w, res & 32'hFFFF, 6 + 6 * w);
          end
        end
      end
      if (img % 2 == 1) begin
        illegal = 0;
        foreach (gr[j]) if (gr[j].addr % img == img - 1 || gr[j].addr >= 2 * outs * img) illegal++;
        vectors++;
        if (illegal != 0) begin
          miscompares++;
          $display("FAIL %s odd-edge reads inst%0d: got %0d want 0", tag, i, illegal);
        end
      end
    end
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int a = 0; a < 1024; a++) begin
      mem0[a] = v;
      mem1[a] = v;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({busy0, done0, rd_en0, wr_en0, rd_addr0, wr_addr0, wr_data0} !== '0) begin
      miscompares++;
      $display("FAIL reset inst0: got busy%b done%b rd%b wr%b ra%0h wa%0h wd%0h want all 0",
               busy0, done0, rd_en0, wr_en0, rd_addr0, wr_addr0, wr_data0);
    end
    vectors++;
    if ({busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1} !== '0) begin
      miscompares++;
      $display("FAIL reset inst1: got busy%b done%b rd%b wr%b ra%0h wa%0h wd%0h want all 0",
               busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1);
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    for (int a = 0; a < 1024; a++) begin
      mem0[a] = 16'(a + 1);
      mem1[a] = 16'(a + 1);
    end
    run_and_verify("ramp_avg", 1'b0, 1'b0, 1'b0);
    run_and_verify("ramp_max", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_extremes();
    fill_const(16'hFFFF);
    run_and_verify("all_m1_avg", 1'b0, 1'b0, 1'b0);
    fill_const(16'h7FFF);
    run_and_verify("all_pos_avg", 1'b0, 1'b0, 1'b0);
    run_and_verify("all_pos_max", 1'b1, 1'b0, 1'b0);
    fill_const(16'h8000);
    run_and_verify("all_neg_avg", 1'b0, 1'b0, 1'b0);
    // Only the k3 pixel of every window is positive.
    for (int a = 0; a < 1024; a++) begin
      mem0[a] = ((a / 4) % 2 == 1 && (a % 4) % 2 == 1) ? 16'h7FFF : 16'h8000;
      mem1[a] = ((a / 5) % 2 == 1 && (a % 5) % 2 == 1) ? 16'h7FFF : 16'h8000;
    end
    run_and_verify("k3_pos_max", 1'b1, 1'b0, 1'b0);
    run_and_verify("k3_pos_avg", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 1024; a++) begin
      mem0[a] = 16'($urandom);
      mem1[a] = 16'($urandom);
    end
    run_and_verify("restart_ignored", 1'b0, 1'b1, 1'b0);
    run_and_verify("immediate_rerun", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t, nw0, nw1;
    clear_queues();
    @(negedge clk);
    mode  = 1'b0;
    start = 1'b1;
    t     = cyc;
    while (cyc < t + 8) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    nw0 = wq0.size();
    nw1 = wq1.size();
    @(posedge clk);
    #1;
    vectors++;
    if ({busy0, done0, rd_en0, wr_en0, rd_addr0, wr_addr0, wr_data0,
         busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset outputs: got busy%b%b rd%b%b ra%0h/%0h wd%0h/%0h want all 0",
               busy0, busy1, rd_en0, rd_en1, rd_addr0, rd_addr1, wr_data0, wr_data1);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (nw0 != 1 || nw1 != 1) begin
      miscompares++;
      $display("FAIL mid_reset pre-abort writes: got %0d/%0d want 1/1", nw0, nw1);
    end
    vectors++;
    if (wq0.size() != nw0 || wq1.size() != nw1 || dq0.size() != 0 || dq1.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset aborted run: got %0d/%0d extra writes %0d/%0d dones want 0",
               wq0.size() - nw0, wq1.size() - nw1, dq0.size(), dq1.size());
    end
    run_and_verify("post_reset_run", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 1024; a++) begin
        mem0[a] = 16'($urandom);
        mem1[a] = 16'($urandom);
      end
      run_and_verify($sformatf("random%0d", r), logic'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    fill_const(16'h0000);
    repeat (2) @(negedge clk);
    test_reset();
    test_ramp();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
